// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, skid state enum and control field offsets for pipeline stages
//
// Purpose : common definitions imported by pipe_slot users and pipe_stage_skid.
// Contents: NOP_INSTR / CTRL_SAFE bubble values, skid_state_t, packed ctrl bit offsets per stage pair.
package pipe_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [7:0]  CTRL_SAFE = 8'h00;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // ID/EX control vector: execute, memory and writeback bits all still pending (9 bits wide).
    localparam int IDEX_ALU_SRC    = 0;
    localparam int IDEX_REG_DST    = 1;
    localparam int IDEX_INV_A      = 2;
    localparam int IDEX_INV_B      = 3;
    localparam int IDEX_CIN        = 4;
    localparam int IDEX_MEM_WRITE  = 5;
    localparam int IDEX_MEM_TO_REG = 6;
    localparam int IDEX_REG_WRITE  = 7;
    localparam int IDEX_DUMP       = 8;
    localparam int IDEX_CTRL_W     = 9;

    // EX/MEM control vector: execute bits already consumed.
    localparam int EXMEM_MEM_WRITE  = 0;
    localparam int EXMEM_MEM_TO_REG = 1;
    localparam int EXMEM_REG_WRITE  = 2;
    localparam int EXMEM_DUMP       = 3;
    localparam int EXMEM_CTRL_W     = 4;

    // MEM/WB control vector: only writeback and dump remain.
    localparam int MEMWB_MEM_TO_REG = 0;
    localparam int MEMWB_REG_WRITE  = 1;
    localparam int MEMWB_DUMP       = 2;
    localparam int MEMWB_CTRL_W     = 3;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - single {instr, data, ctrl} holding slot with valid flag
//
// Purpose : one pipeline entry register; valid is async-reset, payload is not reset.
// Ports   : clk, rst_n    clock / async active-low reset
//           load, clear   capture d_* and set valid / drop valid (clear wins for valid)
//           d_instr, d_data, d_ctrl   entry to capture
//           valid, q_instr, q_data, q_ctrl   held entry
module pipe_slot #(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 112,
    parameter int CTRL_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [DATA_W-1:0]  d_data,
    input  logic [CTRL_W-1:0]  d_ctrl,
    output logic               valid,
    output logic [INSTR_W-1:0] q_instr,
    output logic [DATA_W-1:0]  q_data,
    output logic [CTRL_W-1:0]  q_ctrl
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // Contents are meaningless while valid is low, so these flops skip reset.
    always_ff @(posedge clk) begin
        if (load) begin
            q_instr <= d_instr;
            q_data  <= d_data;
            q_ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage with optional 2-entry skid buffer, flush and bubble insertion
//
// Purpose : carries instr/data/ctrl between two pipeline stages.
// Ports   : clk, rst_n                                 clock / async active-low reset
//           flush                                      synchronous squash of held and incoming entries
//           in_valid, in_ready, in_instr/data/ctrl     upstream side
//           out_valid, out_ready, out_instr/data/ctrl  downstream side (NOP / CTRL_SAFE during bubbles)
//           occupancy                                  entries held, 0..2
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                 INSTR_W   = 16,
    parameter int                 DATA_W    = 112,
    parameter int                 CTRL_W    = 8,
    parameter logic [CTRL_W-1:0]  CTRL_SAFE = pipe_pkg::CTRL_SAFE,
    parameter logic [INSTR_W-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR,
    parameter bit                 SKID_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CTRL_W-1:0]  in_ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [DATA_W-1:0]  out_data,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [1:0]         occupancy
);

    skid_state_t state, state_nxt;

    logic               in_fire, out_fire;
    logic               load_m, load_s, m_from_s;
    logic               m_valid, s_valid;
    logic [INSTR_W-1:0] m_instr, s_instr;
    logic [DATA_W-1:0]  m_data, s_data;
    logic [CTRL_W-1:0]  m_ctrl, s_ctrl;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = m_valid & out_ready;

    always_comb begin
        state_nxt = state;
        load_m    = 1'b0;
        load_s    = 1'b0;
        m_from_s  = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt = ONE;
                    load_m    = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_m = 1'b1;
                end else if (in_fire && SKID_EN) begin
                    state_nxt = FULL;
                    load_s    = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_nxt = ONE;
                    load_m    = 1'b1;
                    m_from_s  = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush discards anything arriving this cycle; a concurrent out_fire has already been taken downstream.
        if (flush) begin
            state_nxt = EMPTY;
            load_m    = 1'b0;
            load_s    = 1'b0;
            m_from_s  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    pipe_slot #(
        .INSTR_W (INSTR_W),
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W)
    ) u_slot_m (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_m),
        .clear   (flush | (out_fire & ~load_m)),
        .d_instr (m_from_s ? s_instr : in_instr),
        .d_data  (m_from_s ? s_data  : in_data),
        .d_ctrl  (m_from_s ? s_ctrl  : in_ctrl),
        .valid   (m_valid),
        .q_instr (m_instr),
        .q_data  (m_data),
        .q_ctrl  (m_ctrl)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic in_ready_q;

            pipe_slot #(
                .INSTR_W (INSTR_W),
                .DATA_W  (DATA_W),
                .CTRL_W  (CTRL_W)
            ) u_slot_s (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (load_s),
                .clear   (flush | m_from_s),
                .d_instr (in_instr),
                .d_data  (in_data),
                .d_ctrl  (in_ctrl),
                .valid   (s_valid),
                .q_instr (s_instr),
                .q_data  (s_data),
                .q_ctrl  (s_ctrl)
            );

            // Registered ready: low only while both slots will be occupied.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    in_ready_q <= 1'b0;
                end else begin
                    in_ready_q <= (state_nxt != FULL);
                end
            end
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign s_valid  = 1'b0;
            assign s_instr  = '0;
            assign s_data   = '0;
            assign s_ctrl   = '0;
            assign in_ready = ~m_valid | out_ready;
        end
    endgenerate

    assign out_valid = m_valid;
    assign out_instr = m_valid ? m_instr : NOP_INSTR;
    assign out_ctrl  = m_valid ? m_ctrl  : CTRL_SAFE;
    assign out_data  = m_data;
    assign occupancy = {s_valid, m_valid & ~s_valid};

endmodule
